// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: request, memory-port and response signals of the data-memory controller.
//
//   slave  : controller side (dmem_ctrl).
//   master : environment side. It drives the LSQ request, flush and the memory
//            read data/response, and observes everything the controller drives.
//
// Signals:
//   flush                        squash the in-flight request's response
//   req_valid/req_ready          request handshake
//   req_rob_id, req_l_s,
//   req_funct3, req_addr,
//   req_wdata                    request payload (l_s: 1=load, 0=store)
//   dmem_addr, dmem_rmask,
//   dmem_wmask, dmem_wdata       memory access, masks valid for one cycle
//   dmem_rdata, dmem_resp        memory read word and response pulse
//   resp_valid, resp_rob_id,
//   resp_rd_data, resp_store,
//   resp_misaligned              result toward the ROB
interface dmem_ctrl_if #(
    parameter int unsigned ROB_ID_SIZE = 3
) ();
    logic                   flush;
    logic                   req_valid;
    logic                   req_ready;
    logic [ROB_ID_SIZE-1:0] req_rob_id;
    logic                   req_l_s;
    logic [2:0]             req_funct3;
    logic [31:0]            req_addr;
    logic [31:0]            req_wdata;

    logic [31:0]            dmem_addr;
    logic [3:0]             dmem_rmask;
    logic [3:0]             dmem_wmask;
    logic [31:0]            dmem_wdata;
    logic [31:0]            dmem_rdata;
    logic                   dmem_resp;

    logic                   resp_valid;
    logic [ROB_ID_SIZE-1:0] resp_rob_id;
    logic [31:0]            resp_rd_data;
    logic                   resp_store;
    logic                   resp_misaligned;

    modport slave (
        input  flush, req_valid, req_rob_id, req_l_s, req_funct3, req_addr, req_wdata,
        input  dmem_rdata, dmem_resp,
        output req_ready, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output resp_valid, resp_rob_id, resp_rd_data, resp_store, resp_misaligned
    );

    modport master (
        output flush, req_valid, req_rob_id, req_l_s, req_funct3, req_addr, req_wdata,
        output dmem_rdata, dmem_resp,
        input  req_ready, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  resp_valid, resp_rob_id, resp_rd_data, resp_store, resp_misaligned
    );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-outstanding data-memory controller between the load/store
// queue and the dmem port. Forms the aligned address, byte masks and shifted
// store data, waits for the memory response and returns an extended load value
// or a store ack tagged with the ROB id. Responses of flushed requests are dropped.
//
// Ports:
//   clk     clock
//   rst_n   asynchronous active-low reset
//   bus_io  dmem_ctrl_if.slave (request, memory port, response)
// All outputs are registered.
module dmem_ctrl #(
    parameter int unsigned ROB_ID_SIZE = 3
) (
    input logic        clk,
    input logic        rst_n,
    dmem_ctrl_if.slave bus_io
);

    typedef enum logic [1:0] {StIdle, StReq, StRespWait} state_e;

    state_e                 state_q;
    logic                   drop_q;
    logic [ROB_ID_SIZE-1:0] rob_id_q;
    logic                   l_s_q;
    logic [2:0]             funct3_q;
    logic [1:0]             off_q;

    logic                   req_ready_q;
    logic [31:0]            dmem_addr_q;
    logic [31:0]            dmem_wdata_q;
    logic [3:0]             rmask_q;
    logic [3:0]             wmask_q;
    logic                   resp_valid_q;
    logic [ROB_ID_SIZE-1:0] resp_rob_id_q;
    logic [31:0]            resp_rd_data_q;
    logic                   resp_store_q;
    logic                   resp_mis_q;

    logic        accept;
    logic        req_mis;
    logic [3:0]  req_mask;
    logic [1:0]  req_off;
    logic [31:0] shifted;
    logic [31:0] load_data;

    assign req_off = bus_io.req_addr[1:0];

    always_comb begin
        accept = bus_io.req_valid && req_ready_q && !bus_io.flush;
        // funct3[1:0] gives the access size for both loads and stores.
        unique case (bus_io.req_funct3[1:0])
            2'b00: begin
                req_mis  = 1'b0;
                req_mask = 4'b0001 << req_off;
            end
            2'b01: begin
                req_mis  = req_off[0];
                req_mask = 4'b0011 << req_off;
            end
            default: begin
                req_mis  = (req_off != 2'b00);
                req_mask = 4'b1111;
            end
        endcase
    end

    always_comb begin
        shifted = bus_io.dmem_rdata >> {off_q, 3'b000};
        unique case (funct3_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'h0, shifted[7:0]};
            3'b101:  load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            drop_q         <= 1'b0;
            rob_id_q       <= '0;
            l_s_q          <= 1'b0;
            funct3_q       <= 3'b000;
            off_q          <= 2'b00;
            req_ready_q    <= 1'b1;
            dmem_addr_q    <= 32'h0;
            dmem_wdata_q   <= 32'h0;
            rmask_q        <= 4'h0;
            wmask_q        <= 4'h0;
            resp_valid_q   <= 1'b0;
            resp_rob_id_q  <= '0;
            resp_rd_data_q <= 32'h0;
            resp_store_q   <= 1'b0;
            resp_mis_q     <= 1'b0;
        end else begin
            // Pulses and masks default low; masks are only set for the REQ cycle.
            resp_valid_q <= 1'b0;
            resp_store_q <= 1'b0;
            resp_mis_q   <= 1'b0;
            rmask_q      <= 4'h0;
            wmask_q      <= 4'h0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        rob_id_q <= bus_io.req_rob_id;
                        l_s_q    <= bus_io.req_l_s;
                        funct3_q <= bus_io.req_funct3;
                        off_q    <= req_off;
                        if (req_mis) begin
                            // Rejected without touching memory; answer next cycle.
                            resp_valid_q   <= 1'b1;
                            resp_mis_q     <= 1'b1;
                            resp_store_q   <= !bus_io.req_l_s;
                            resp_rob_id_q  <= bus_io.req_rob_id;
                            resp_rd_data_q <= 32'h0;
                        end else begin
                            state_q      <= StReq;
                            req_ready_q  <= 1'b0;
                            dmem_addr_q  <= {bus_io.req_addr[31:2], 2'b00};
                            dmem_wdata_q <= bus_io.req_wdata << {req_off, 3'b000};
                            if (bus_io.req_l_s) begin
                                rmask_q <= req_mask;
                            end else begin
                                wmask_q <= req_mask;
                            end
                        end
                    end
                end
                StReq: begin
                    state_q <= StRespWait;
                    if (bus_io.flush) begin
                        drop_q <= 1'b1;
                    end
                end
                StRespWait: begin
                    if (bus_io.dmem_resp) begin
                        state_q     <= StIdle;
                        req_ready_q <= 1'b1;
                        drop_q      <= 1'b0;
                        // A flush arriving with the response also kills it.
                        if (!drop_q && !bus_io.flush) begin
                            resp_valid_q   <= 1'b1;
                            resp_store_q   <= !l_s_q;
                            resp_rob_id_q  <= rob_id_q;
                            resp_rd_data_q <= l_s_q ? load_data : 32'h0;
                        end
                    end else if (bus_io.flush) begin
                        drop_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus_io.req_ready       = req_ready_q;
    assign bus_io.dmem_addr       = dmem_addr_q;
    assign bus_io.dmem_wdata      = dmem_wdata_q;
    assign bus_io.dmem_rmask      = rmask_q;
    assign bus_io.dmem_wmask      = wmask_q;
    assign bus_io.resp_valid      = resp_valid_q;
    assign bus_io.resp_rob_id     = resp_rob_id_q;
    assign bus_io.resp_rd_data    = resp_rd_data_q;
    assign bus_io.resp_store      = resp_store_q;
    assign bus_io.resp_misaligned = resp_mis_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl: directed requests with hand-computed expectations
// pushed into scoreboard queues; negedge monitors pop and compare whenever the
// DUT shows a memory access (nonzero mask) or a result (resp_valid).
module tb_dmem_ctrl;

    logic clk;
    logic rst_n;

    dmem_ctrl_if #(.ROB_ID_SIZE(3)) bus ();

    dmem_ctrl #(.ROB_ID_SIZE(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } dmem_exp_t;

    typedef struct {
        logic [2:0]  rob;
        logic [31:0] data;
        logic        store;
        logic        mis;
    } resp_exp_t;

    dmem_exp_t dq[$];
    resp_exp_t rq[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_dmem(input logic [31:0] a, input logic [3:0] r, input logic [3:0] w,
                             input logic [31:0] wd);
        dmem_exp_t e;
        e.addr = a; e.rmask = r; e.wmask = w; e.wdata = wd;
        dq.push_back(e);
    endtask

    task automatic push_resp(input logic [2:0] rob, input logic [31:0] d, input logic st,
                             input logic mis);
        resp_exp_t e;
        e.rob = rob; e.data = d; e.store = st; e.mis = mis;
        rq.push_back(e);
    endtask

    // Memory-access monitor.
    always @(negedge clk) begin
        dmem_exp_t de;
        if (rst_n && (bus.dmem_rmask != 4'h0 || bus.dmem_wmask != 4'h0)) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dmem_unexpected: got addr %h rmask %b wmask %b expected no access",
                         bus.dmem_addr, bus.dmem_rmask, bus.dmem_wmask);
            end else begin
                de = dq.pop_front();
                check("dmem_addr", bus.dmem_addr, de.addr);
                check("dmem_rmask", {28'h0, bus.dmem_rmask}, {28'h0, de.rmask});
                check("dmem_wmask", {28'h0, bus.dmem_wmask}, {28'h0, de.wmask});
                check("dmem_wdata", bus.dmem_wdata, de.wdata);
            end
        end
    end

    // Result monitor.
    always @(negedge clk) begin
        resp_exp_t re;
        if (bus.resp_valid) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got rob %0d data %h expected no resp_valid",
                         bus.resp_rob_id, bus.resp_rd_data);
            end else begin
                re = rq.pop_front();
                check("resp_rob_id", {29'h0, bus.resp_rob_id}, {29'h0, re.rob});
                check("resp_rd_data", bus.resp_rd_data, re.data);
                check("resp_store", {31'h0, bus.resp_store}, {31'h0, re.store});
                check("resp_misaligned", {31'h0, bus.resp_misaligned}, {31'h0, re.mis});
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {31'h0, bus.req_ready}, 32'h1);
        check({tag, "_dmem_addr"}, bus.dmem_addr, 32'h0);
        check({tag, "_masks"}, {24'h0, bus.dmem_rmask, bus.dmem_wmask}, 32'h0);
        check({tag, "_dmem_wdata"}, bus.dmem_wdata, 32'h0);
        check({tag, "_resp_flags"},
              {29'h0, bus.resp_valid, bus.resp_store, bus.resp_misaligned}, 32'h0);
        check({tag, "_resp_rob_id"}, {29'h0, bus.resp_rob_id}, 32'h0);
        check({tag, "_resp_rd_data"}, bus.resp_rd_data, 32'h0);
    endtask

    // Called #1 after a posedge; returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] rob, input logic ls, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got req_ready 0 expected 1 within 20 cycles");
        end
        bus.req_valid  = 1'b1;
        bus.req_rob_id = rob;
        bus.req_l_s    = ls;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Called in the REQ cycle. Flush optionally in the first RESP_WAIT cycle
    // and/or together with the response.
    task automatic mem_resp(input int wait_cycles, input logic [31:0] rdata,
                            input logic fl_wait, input logic fl_resp);
        @(posedge clk);
        #1;
        bus.flush = fl_wait;
        repeat (wait_cycles) begin
            @(posedge clk);
            #1;
            bus.flush = 1'b0;
        end
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = rdata;
        bus.flush      = bus.flush | fl_resp;
        @(posedge clk);
        #1;
        bus.dmem_resp = 1'b0;
        bus.flush     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.flush      = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_rob_id = 3'd0;
        bus.req_l_s    = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.dmem_rdata = 32'h0;
        bus.dmem_resp  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // lw, aligned
        push_dmem(32'h1000_0004, 4'b1111, 4'b0000, 32'h0);
        push_resp(3'd5, 32'hDEAD_BEEF, 1'b0, 1'b0);
        issue(3'd5, 1'b1, 3'b010, 32'h1000_0004, 32'h0);
        mem_resp(0, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // lb / lbu at offset 3
        push_dmem(32'h1000_0000, 4'b1000, 4'b0000, 32'h0);
        push_resp(3'd1, 32'hFFFF_FF80, 1'b0, 1'b0);
        issue(3'd1, 1'b1, 3'b000, 32'h1000_0003, 32'h0);
        mem_resp(0, 32'h80FF_0000, 1'b0, 1'b0);
        push_dmem(32'h1000_0000, 4'b1000, 4'b0000, 32'h0);
        push_resp(3'd2, 32'h0000_0080, 1'b0, 1'b0);
        issue(3'd2, 1'b1, 3'b100, 32'h1000_0003, 32'h0);
        mem_resp(1, 32'h80FF_0000, 1'b0, 1'b0);

        // sh at offset 2
        push_dmem(32'h1000_0000, 4'b0000, 4'b1100, 32'hABCD_0000);
        push_resp(3'd3, 32'h0, 1'b1, 1'b0);
        issue(3'd3, 1'b0, 3'b001, 32'h1000_0002, 32'h1234_ABCD);
        mem_resp(0, 32'h5555_5555, 1'b0, 1'b0);

        // misaligned lw: no memory access, result next cycle, ready stays high
        push_resp(3'd4, 32'h0, 1'b0, 1'b1);
        issue(3'd4, 1'b1, 3'b010, 32'h1000_0002, 32'h0);
        check("mis_req_ready", {31'h0, bus.req_ready}, 32'h1);
        @(posedge clk);
        #1;

        // request offered together with flush is not accepted
        bus.req_valid  = 1'b1;
        bus.flush      = 1'b1;
        bus.req_rob_id = 3'd6;
        bus.req_l_s    = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h5000_0000;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        check("flush_req_not_taken", {31'h0, bus.req_ready}, 32'h1);

        // flush during RESP_WAIT, response 3 cycles later: dropped
        push_dmem(32'h2000_0000, 4'b1100, 4'b0000, 32'h0);
        issue(3'd6, 1'b1, 3'b001, 32'h2000_0002, 32'h0);
        mem_resp(3, 32'h1234_5678, 1'b1, 1'b0);

        // follow-up lhu / lh answered normally
        push_dmem(32'h2000_0000, 4'b1100, 4'b0000, 32'h0);
        push_resp(3'd7, 32'h0000_8765, 1'b0, 1'b0);
        issue(3'd7, 1'b1, 3'b101, 32'h2000_0002, 32'h0);
        mem_resp(0, 32'h8765_4321, 1'b0, 1'b0);
        push_dmem(32'h2000_0004, 4'b1100, 4'b0000, 32'h0);
        push_resp(3'd0, 32'hFFFF_8765, 1'b0, 1'b0);
        issue(3'd0, 1'b1, 3'b001, 32'h2000_0006, 32'h0);
        mem_resp(0, 32'h8765_4321, 1'b0, 1'b0);

        // sb at offset 1
        push_dmem(32'h3000_0000, 4'b0000, 4'b0010, 32'h0000_A500);
        push_resp(3'd1, 32'h0, 1'b1, 1'b0);
        issue(3'd1, 1'b0, 3'b000, 32'h3000_0001, 32'h0000_00A5);
        mem_resp(0, 32'h0, 1'b0, 1'b0);

        // flush coincident with dmem_resp: dropped
        push_dmem(32'h3000_0008, 4'b1111, 4'b0000, 32'h0);
        issue(3'd2, 1'b1, 3'b010, 32'h3000_0008, 32'h0);
        mem_resp(1, 32'h1111_2222, 1'b0, 1'b1);

        // reset during RESP_WAIT, late response ignored
        push_dmem(32'h4000_0000, 4'b1111, 4'b0000, 32'h0);
        issue(3'd3, 1'b1, 3'b010, 32'h4000_0000, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = 32'h9999_9999;
        @(posedge clk);
        #1;
        bus.dmem_resp = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_idle", {31'h0, bus.req_ready}, 32'h1);

        // sw after reset
        push_dmem(32'h4000_0010, 4'b0000, 4'b1111, 32'hCAFE_F00D);
        push_resp(3'd5, 32'h0, 1'b1, 1'b0);
        issue(3'd5, 1'b0, 3'b010, 32'h4000_0010, 32'hCAFE_F00D);
        mem_resp(0, 32'h0, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("dmem_queue_drained", dq.size(), 32'd0);
        check("resp_queue_drained", rq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
